// File: rtl/elm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elm_pkg
// Description : Shared constants and FSM state encoding for the ELM output
//               accumulator (class count, score width, data width).
// Revision    : 1.0 - initial release
// ============================================================================
package elm_pkg;

  localparam int ELM_N_CLASS = 10;
  localparam int ELM_ACC_W   = 48;
  localparam int ELM_DW      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } elm_state_e;

endpackage : elm_pkg
`default_nettype wire

// File: rtl/elm_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : elm_mac_unit
// Description : Combinational signed multiply-accumulate step.
//               acc_out = acc_in + sext(a * b), product kept at full 2*DW
//               width before sign extension; the add wraps in two's
//               complement.
// Ports       : a, b    - signed DW-bit operands
//               acc_in  - signed ACC_W-bit running sum
//               acc_out - signed ACC_W-bit updated sum
// Revision    : 1.0 - initial release
// ============================================================================
module elm_mac_unit
  import elm_pkg::*;
#(
  parameter int DW    = ELM_DW,
  parameter int ACC_W = ELM_ACC_W
) (
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [ACC_W-1:0] acc_out
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = a * b;
  // prod is signed, so the size cast sign-extends to the accumulator width.
  assign prod_ext = ACC_W'(prod);
  assign acc_out  = acc_in + prod_ext;

endmodule : elm_mac_unit
`default_nettype wire

// File: rtl/elm_output_accum.sv
`default_nettype none
// ============================================================================
// Module      : elm_output_accum
// Description : Output-layer accumulator of the ELM engine. Accepts one
//               hidden activation plus its N_CLASS output weights per beat
//               and folds the beat into N_CLASS signed score accumulators,
//               one class per cycle, through a single shared MAC.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               start          - pulse, begins an inference (ignored in ACCUM)
//               h_valid/h_ready- beat handshake
//               h_data         - signed activation
//               w_data         - packed signed weights, class k at slot k
//               bias           - packed signed biases (ELM_OUT_BIAS_EN only)
//               scores         - packed class scores, class k at slot k
//               scores_valid   - level, scores final and stable
//               busy           - high while accumulating
// Config      : `define ELM_OUT_BIAS_EN adds the bias port; accumulators are
//               then loaded with sext(bias[k]) on the start edge instead of 0.
// Revision    : 1.0 - initial release
// ============================================================================
module elm_output_accum
  import elm_pkg::*;
#(
  parameter int N_HIDDEN = 64,
  parameter int DW       = ELM_DW,
  parameter int ACC_W    = ELM_ACC_W,
  parameter int N_CLASS  = ELM_N_CLASS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     h_valid,
  output logic                     h_ready,
  input  logic [DW-1:0]            h_data,
  input  logic [N_CLASS*DW-1:0]    w_data,
`ifdef ELM_OUT_BIAS_EN
  input  logic [N_CLASS*DW-1:0]    bias,
`endif
  output logic [N_CLASS*ACC_W-1:0] scores,
  output logic                     scores_valid,
  output logic                     busy
);

  localparam int HW = $clog2(N_HIDDEN + 1);
  localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam logic [HW-1:0] LAST_HID = HW'(N_HIDDEN - 1);
  localparam logic [CW-1:0] LAST_CLS = CW'(N_CLASS - 1);

  elm_state_e state_q, state_d;
  logic [HW-1:0] hid_cnt_q, hid_cnt_d;
  logic [CW-1:0] cls_idx_q, cls_idx_d;
  logic          mac_busy_q, mac_busy_d;
  logic signed [DW-1:0]    h_reg_q, h_reg_d;
  logic signed [DW-1:0]    w_reg_q  [N_CLASS];
  logic signed [DW-1:0]    w_reg_d  [N_CLASS];
  logic signed [ACC_W-1:0] acc_q    [N_CLASS];
  logic signed [ACC_W-1:0] acc_d    [N_CLASS];
  logic signed [DW-1:0]    w_in     [N_CLASS];
  logic signed [ACC_W-1:0] init_val [N_CLASS];
  logic signed [ACC_W-1:0] mac_out;

  // Unpack the flat buses into per-class views and expose the accumulators.
  for (genvar k = 0; k < N_CLASS; k++) begin : g_cls
    assign w_in[k] = $signed(w_data[k*DW +: DW]);
`ifdef ELM_OUT_BIAS_EN
    assign init_val[k] = ACC_W'($signed(bias[k*DW +: DW]));
`else
    assign init_val[k] = '0;
`endif
    assign scores[k*ACC_W +: ACC_W] = acc_q[k];
  end

  elm_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .a       (h_reg_q),
    .b       (w_reg_q[cls_idx_q]),
    .acc_in  (acc_q[cls_idx_q]),
    .acc_out (mac_out)
  );

  always_comb begin
    state_d    = state_q;
    hid_cnt_d  = hid_cnt_q;
    cls_idx_d  = cls_idx_q;
    mac_busy_d = mac_busy_q;
    h_reg_d    = h_reg_q;
    for (int k = 0; k < N_CLASS; k++) begin
      w_reg_d[k] = w_reg_q[k];
      acc_d[k]   = acc_q[k];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_ACCUM;
          hid_cnt_d  = '0;
          cls_idx_d  = '0;
          mac_busy_d = 1'b0;
          for (int k = 0; k < N_CLASS; k++) acc_d[k] = init_val[k];
        end
      end
      ST_ACCUM: begin
        if (mac_busy_q) begin
          acc_d[cls_idx_q] = mac_out;
          if (cls_idx_q == LAST_CLS) begin
            mac_busy_d = 1'b0;
            cls_idx_d  = '0;
            hid_cnt_d  = hid_cnt_q + 1'b1;
            if (hid_cnt_q == LAST_HID) state_d = ST_DONE;
          end else begin
            cls_idx_d = cls_idx_q + 1'b1;
          end
        end else if (h_valid) begin
          // h_ready is high here, so this is an accepted beat.
          h_reg_d    = $signed(h_data);
          mac_busy_d = 1'b1;
          for (int k = 0; k < N_CLASS; k++) w_reg_d[k] = w_in[k];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hid_cnt_q  <= '0;
      cls_idx_q  <= '0;
      mac_busy_q <= 1'b0;
      h_reg_q    <= '0;
      for (int k = 0; k < N_CLASS; k++) begin
        w_reg_q[k] <= '0;
        acc_q[k]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      hid_cnt_q  <= hid_cnt_d;
      cls_idx_q  <= cls_idx_d;
      mac_busy_q <= mac_busy_d;
      h_reg_q    <= h_reg_d;
      for (int k = 0; k < N_CLASS; k++) begin
        w_reg_q[k] <= w_reg_d[k];
        acc_q[k]   <= acc_d[k];
      end
    end
  end

  assign h_ready      = (state_q == ST_ACCUM) && !mac_busy_q;
  assign busy         = (state_q == ST_ACCUM);
  assign scores_valid = (state_q == ST_DONE);

endmodule : elm_output_accum
`default_nettype wire
